// File: rtl/shannon_whitaker_lp_ctrl_pkg.sv
// Shared types and defaults for the super-sample lowpass run sequencer.
// The output decode lives here so that the FSM and its registered outputs stay in step.
package shannon_whitaker_pkg;

  typedef enum logic [2:0] {IDLE, HOLD, FLUSH, PRIME, RUN, DRAIN} sw_ctrl_state_t;

  localparam int NSAMPS           = 8;
  localparam int DEF_HOLD_CYCLES  = 2;
  localparam int DEF_FLUSH_CYCLES = 8;
  localparam int DEF_LATENCY      = 10;
  localparam int DEF_CNTBITS      = 16;

  typedef struct packed {
    logic filt_rst;
    logic zero;
    logic valid;
    logic busy;
  } sw_ctrl_out_t;

  // Filter-side qualifiers implied by being in a given state.
  function automatic sw_ctrl_out_t decode_outputs(sw_ctrl_state_t st);
    sw_ctrl_out_t o;
    o = '{filt_rst: 1'b1, zero: 1'b1, valid: 1'b0, busy: 1'b0};
    case (st)
      HOLD:    o = '{filt_rst: 1'b1, zero: 1'b1, valid: 1'b0, busy: 1'b1};
      FLUSH:   o = '{filt_rst: 1'b0, zero: 1'b1, valid: 1'b0, busy: 1'b1};
      PRIME:   o = '{filt_rst: 1'b0, zero: 1'b0, valid: 1'b0, busy: 1'b1};
      RUN:     o = '{filt_rst: 1'b0, zero: 1'b0, valid: 1'b1, busy: 1'b1};
      DRAIN:   o = '{filt_rst: 1'b0, zero: 1'b1, valid: 1'b1, busy: 1'b1};
      default: o = '{filt_rst: 1'b1, zero: 1'b1, valid: 1'b0, busy: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/shannon_whitaker_lp_ctrl_if.sv
// Run-control and snapshot signals between the register block (master) and the sequencer (slave).
interface shannon_whitaker_lp_ctrl_if #(
  parameter int NSAMPS  = 8,
  parameter int CNTBITS = 16
);
  logic               en_i;
  logic               filt_rst_o;
  logic               zero_o;
  logic               valid_o;
  logic               busy_o;
  logic [NSAMPS-1:0]  sat_i;
  logic               snap_req_i;
  logic               snap_ack_o;
  logic [CNTBITS-1:0] sat_cnt_o;

  modport master (
    output en_i, sat_i, snap_req_i,
    input  filt_rst_o, zero_o, valid_o, busy_o, snap_ack_o, sat_cnt_o
  );

  modport slave (
    input  en_i, sat_i, snap_req_i,
    output filt_rst_o, zero_o, valid_o, busy_o, snap_ack_o, sat_cnt_o
  );
endinterface

// File: rtl/shannon_whitaker_lp_ctrl_sat.sv
// Saturation event counter with a 4-phase snapshot handshake towards a register reader.
// A capture includes the current cycle's event, which also seeds the restarted live count.
module sat_snapshot_counter
  import shannon_whitaker_pkg::*;
#(
  parameter int NSAMPS  = shannon_whitaker_pkg::NSAMPS,
  parameter int CNTBITS = DEF_CNTBITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid,
  input  logic [NSAMPS-1:0]  sat,
  input  logic               snap_req,
  output logic               snap_ack,
  output logic [CNTBITS-1:0] sat_cnt
);

  localparam logic [CNTBITS-1:0] MAXCNT = '1;

  logic               inc;
  logic [CNTBITS-1:0] live;
  logic [CNTBITS-1:0] bumped;

  assign inc    = valid && (|sat);
  assign bumped = (inc && (live != MAXCNT)) ? live + 1'b1 : live;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live     <= '0;
      sat_cnt  <= '0;
      snap_ack <= 1'b0;
    end else if (snap_req && !snap_ack) begin
      sat_cnt  <= bumped;
      live     <= CNTBITS'(inc);
      snap_ack <= 1'b1;
    end else begin
      live <= bumped;
      if (!snap_req)
        snap_ack <= 1'b0;
    end
  end

endmodule

// File: rtl/shannon_whitaker_lp_ctrl.sv
// Run sequencer for the 8-lane lowpass: reset, zero-flush, prime, run and drain the filter,
// plus a saturation event counter readable through a snapshot handshake.
module shannon_whitaker_lp_ctrl
  import shannon_whitaker_pkg::*;
#(
  parameter int NSAMPS       = shannon_whitaker_pkg::NSAMPS,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int LATENCY      = DEF_LATENCY,
  parameter int CNTBITS      = DEF_CNTBITS
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  shannon_whitaker_lp_ctrl_if.slave bus
);

  localparam int MAXLEN = (HOLD_CYCLES > FLUSH_CYCLES)
                          ? ((HOLD_CYCLES > LATENCY) ? HOLD_CYCLES : LATENCY)
                          : ((FLUSH_CYCLES > LATENCY) ? FLUSH_CYCLES : LATENCY);
  localparam int PW = $clog2(MAXLEN) + 1;

  sw_ctrl_state_t state;
  sw_ctrl_state_t nxt;
  logic [PW-1:0]  phase;
  sw_ctrl_out_t   outs;

  // Remaining-cycle count loaded on entry; states without a duration just park at zero.
  function automatic logic [PW-1:0] phase_len(sw_ctrl_state_t st);
    case (st)
      HOLD:         return PW'(HOLD_CYCLES - 1);
      FLUSH:        return PW'(FLUSH_CYCLES - 1);
      PRIME, DRAIN: return PW'(LATENCY - 1);
      default:      return '0;
    endcase
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (bus.en_i) nxt = HOLD;
      HOLD:  if (!bus.en_i) nxt = IDLE; else if (phase == '0) nxt = FLUSH;
      FLUSH: if (!bus.en_i) nxt = IDLE; else if (phase == '0) nxt = PRIME;
      PRIME: if (!bus.en_i) nxt = IDLE; else if (phase == '0) nxt = RUN;
      RUN:   if (!bus.en_i) nxt = DRAIN;
      DRAIN: if (phase == '0) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they move in the same cycle as the state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      phase <= '0;
      outs  <= decode_outputs(IDLE);
    end else begin
      state <= nxt;
      outs  <= decode_outputs(nxt);
      if (nxt != state)
        phase <= phase_len(nxt);
      else if (phase != '0)
        phase <= phase - 1'b1;
    end
  end

  assign bus.filt_rst_o = outs.filt_rst;
  assign bus.zero_o     = outs.zero;
  assign bus.valid_o    = outs.valid;
  assign bus.busy_o     = outs.busy;

  sat_snapshot_counter #(
    .NSAMPS  (NSAMPS),
    .CNTBITS (CNTBITS)
  ) u_sat (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .valid    (outs.valid),
    .sat      (bus.sat_i),
    .snap_req (bus.snap_req_i),
    .snap_ack (bus.snap_ack_o),
    .sat_cnt  (bus.sat_cnt_o)
  );

endmodule

// File: tb/tb_shannon_whitaker_lp_ctrl.sv
// Directed bench for the lowpass run sequencer, with a frozen-while-reset delay line standing in for the filter.
module tb_shannon_whitaker_lp_ctrl;

  localparam int          LAT = 10;
  localparam logic [15:0] IMP = 16'h7fff;

  logic clk = 1'b0;
  logic rst_n;
  logic rst4_n;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  shannon_whitaker_lp_ctrl_if #(.NSAMPS(8), .CNTBITS(16)) bus ();
  shannon_whitaker_lp_ctrl_if #(.NSAMPS(8), .CNTBITS(4))  bus4 ();

  shannon_whitaker_lp_ctrl #(.CNTBITS(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  shannon_whitaker_lp_ctrl #(.CNTBITS(4)) dut4 (
    .clk_i  (clk),
    .rst_ni (rst4_n),
    .bus    (bus4)
  );

  // Filter stand-in: input mux forced to zero by zero_o, delay frozen while filt_rst_o is high.
  logic [15:0] din;
  logic [15:0] pipe [LAT];
  wire  [15:0] dat = pipe[LAT-1];
  wire  [3:0]  obs  = {bus.filt_rst_o, bus.zero_o, bus.valid_o, bus.busy_o};
  wire  [3:0]  obs4 = {bus4.filt_rst_o, bus4.zero_o, bus4.valid_o, bus4.busy_o};

  always @(posedge clk) begin
    if (bus.filt_rst_o === 1'b0) begin
      pipe[0] <= bus.zero_o ? 16'd0 : din;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  task tick();
    @(posedge clk);
    #1;
  endtask

  task start_run();
    bus.en_i = 1'b1;
    repeat (21) tick();
  endtask

  task test_reset();
    rst_n = 1'b0; rst4_n = 1'b0; din = '0;
    bus.en_i = 1'b0;  bus.sat_i = '0;  bus.snap_req_i = 1'b0;
    bus4.en_i = 1'b0; bus4.sat_i = '0; bus4.snap_req_i = 1'b0;
    tick(); tick();
    vectors++; if (obs !== 4'b1100) begin miscompares++; $display("[TB] FAIL reset_outs got %b want 1100", obs); end
    vectors++; if (bus.snap_ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ack got %b want 0", bus.snap_ack_o); end
    vectors++; if (bus.sat_cnt_o !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_cnt got %0d want 0", bus.sat_cnt_o); end
    rst_n = 1'b1;
    tick();
    vectors++; if (obs !== 4'b1100) begin miscompares++; $display("[TB] FAIL idle_outs got %b want 1100", obs); end
  endtask

  task test_startup();
    logic [3:0] exp;
    bus.en_i = 1'b1;
    vectors++; if (obs !== 4'b1100) begin miscompares++; $display("[TB] FAIL start_c0 got %b want 1100", obs); end
    for (int c = 1; c <= 22; c++) begin
      tick();
      din = (c == 11) ? IMP : 16'd0;
      exp = (c <= 2) ? 4'b1101 : (c <= 10) ? 4'b0101 : (c <= 20) ? 4'b0001 : 4'b0011;
      vectors++; if (obs !== exp) begin miscompares++; $display("[TB] FAIL start_c%0d got %b want %b", c, obs, exp); end
      if (c == 21) begin
        vectors++; if (dat !== IMP) begin miscompares++; $display("[TB] FAIL impulse got %h want %h", dat, IMP); end
      end
    end
  endtask

  task test_drain();
    logic [3:0] exp;
    bus.en_i = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      exp = (c <= 10) ? 4'b0111 : (c == 12) ? 4'b1101 : 4'b1100;
      vectors++; if (obs !== exp) begin miscompares++; $display("[TB] FAIL drain_c%0d got %b want %b", c, obs, exp); end
      if (c == 5)  bus.en_i = 1'b1;
      if (c == 12) bus.en_i = 1'b0;
    end
  endtask

  task test_abort_flush();
    bus.en_i = 1'b1;
    repeat (4) tick();
    vectors++; if (obs !== 4'b0101) begin miscompares++; $display("[TB] FAIL flush_state got %b want 0101", obs); end
    bus.en_i = 1'b0;
    tick();
    vectors++; if (obs !== 4'b1100) begin miscompares++; $display("[TB] FAIL abort_idle got %b want 1100", obs); end
    tick();
    vectors++; if (obs !== 4'b1100) begin miscompares++; $display("[TB] FAIL abort_stay got %b want 1100", obs); end
  endtask

  task test_reset_mid_run();
    start_run();
    vectors++; if (obs !== 4'b0011) begin miscompares++; $display("[TB] FAIL run_reached got %b want 0011", obs); end
    bus.snap_req_i = 1'b1; bus.sat_i = 8'h01;
    tick();
    vectors++; if (bus.sat_cnt_o !== 16'd1) begin miscompares++; $display("[TB] FAIL inc_capture got %0d want 1", bus.sat_cnt_o); end
    rst_n = 1'b0;
    tick();
    vectors++; if (obs !== 4'b1100) begin miscompares++; $display("[TB] FAIL midrst_outs got %b want 1100", obs); end
    vectors++; if (bus.snap_ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_ack got %b want 0", bus.snap_ack_o); end
    vectors++; if (bus.sat_cnt_o !== 16'd0) begin miscompares++; $display("[TB] FAIL midrst_cnt got %0d want 0", bus.sat_cnt_o); end
    bus.en_i = 1'b0; bus.snap_req_i = 1'b0; bus.sat_i = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task test_snapshot();
    start_run();
    bus.sat_i = 8'h80;
    repeat (5) tick();
    bus.sat_i = '0; bus.snap_req_i = 1'b1;
    tick();
    vectors++; if (bus.snap_ack_o !== 1'b1) begin miscompares++; $display("[TB] FAIL snap_ack got %b want 1", bus.snap_ack_o); end
    vectors++; if (bus.sat_cnt_o !== 16'd5) begin miscompares++; $display("[TB] FAIL snap_cnt got %0d want 5", bus.sat_cnt_o); end
    bus.sat_i = 8'h03;
    tick(); tick();
    vectors++; if (bus.sat_cnt_o !== 16'd5) begin miscompares++; $display("[TB] FAIL held_cnt got %0d want 5", bus.sat_cnt_o); end
    vectors++; if (bus.snap_ack_o !== 1'b1) begin miscompares++; $display("[TB] FAIL held_ack got %b want 1", bus.snap_ack_o); end
    bus.sat_i = '0; bus.snap_req_i = 1'b0;
    tick();
    vectors++; if (bus.snap_ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL ack_fall got %b want 0", bus.snap_ack_o); end
    bus.snap_req_i = 1'b1;
    tick();
    vectors++; if (bus.sat_cnt_o !== 16'd2) begin miscompares++; $display("[TB] FAIL second_cnt got %0d want 2", bus.sat_cnt_o); end
    bus.snap_req_i = 1'b0;
    tick();
    bus.snap_req_i = 1'b1; bus.sat_i = 8'h10;
    tick();
    vectors++; if (bus.sat_cnt_o !== 16'd1) begin miscompares++; $display("[TB] FAIL inc_snap_cnt got %0d want 1", bus.sat_cnt_o); end
    bus.snap_req_i = 1'b0; bus.sat_i = '0;
    tick();
    bus.snap_req_i = 1'b1;
    tick();
    vectors++; if (bus.sat_cnt_o !== 16'd1) begin miscompares++; $display("[TB] FAIL live_seed got %0d want 1", bus.sat_cnt_o); end
    bus.snap_req_i = 1'b0;
    tick();
  endtask

  task test_saturation();
    rst4_n = 1'b1;
    tick();
    bus4.en_i = 1'b1;
    repeat (21) tick();
    vectors++; if (obs4 !== 4'b0011) begin miscompares++; $display("[TB] FAIL sat_run got %b want 0011", obs4); end
    bus4.sat_i = 8'hff;
    repeat (20) tick();
    bus4.sat_i = '0; bus4.snap_req_i = 1'b1;
    tick();
    vectors++; if (bus4.sat_cnt_o !== 4'hf) begin miscompares++; $display("[TB] FAIL sat_limit got %0d want 15", bus4.sat_cnt_o); end
    bus4.snap_req_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_drain();
    test_abort_flush();
    test_reset_mid_run();
    test_snapshot();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
